// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited sequential imem fetches feeding a circular
// buffer whose oldest FETCH_LEN entries are presented to the scheduler each cycle.
module fetch_queue #(
    parameter int              XLEN      = 32,
    parameter int              FETCH_LEN = 4,
    parameter int              FETCH_OFF = 3,
    parameter int              BUF_LEN   = 8,
    parameter int              MAX_OUTS  = 2,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0200
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [XLEN-1:0]           imem_addr,
    input  logic                      imem_gnt,
    input  logic                      imem_resp_vld,
    input  logic [XLEN-1:0]           imem_resp_instr,
    input  logic                      imem_resp_err,
    input  logic                      jump_vld,
    input  logic [XLEN-1:0]           jump_pc,
    output logic [FETCH_LEN-1:0]      fetch_vld,
    output logic [FETCH_LEN*XLEN-1:0] fetch_instr,
    output logic [FETCH_LEN*XLEN-1:0] fetch_pc,
    output logic [FETCH_LEN-1:0]      fetch_err,
    input  logic [FETCH_OFF-1:0]      fetch_offset
);

    localparam int PTR_W  = $clog2(BUF_LEN);
    localparam int CNT_W  = $clog2(BUF_LEN + 1);
    localparam int OUT_W  = $clog2(MAX_OUTS + 1);
    localparam int SUM_W  = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;
    // Headroom so several back-to-back redirects can stack discards without wrapping.
    localparam int DROP_W = OUT_W + 4;

    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [OUT_W-1:0]  r_inflight;
    logic [DROP_W-1:0] r_drop_cnt;
    logic [XLEN-1:0]   r_req_pc;
    logic [XLEN-1:0]   r_resp_pc;
    logic              r_err_hold;

    logic [XLEN-1:0]   r_buf_instr [BUF_LEN];
    logic [XLEN-1:0]   r_buf_pc    [BUF_LEN];
    logic              r_buf_err   [BUF_LEN];

    logic [CNT_W-1:0]  w_offset_ext;
    logic [CNT_W-1:0]  w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_credit;
    logic              w_req;
    logic              w_grant;
    logic [DROP_W-1:0] w_drop_sum;
    logic [DROP_W-1:0] w_drop_jump;

    // Pop is clamped to what is actually queued.
    assign w_offset_ext = CNT_W'(fetch_offset);
    assign w_pop        = (w_offset_ext > r_count) ? r_count : w_offset_ext;

    assign w_push = imem_resp_vld & (r_drop_cnt == '0);
    assign w_drop = imem_resp_vld & (r_drop_cnt != '0);

    // Reserving a slot per outstanding request keeps the buffer from overflowing.
    assign w_credit = (SUM_W'(r_count) + SUM_W'(r_inflight)) < SUM_W'(BUF_LEN);
    assign w_req    = ~rst & ~r_err_hold & ~jump_vld
                    & (r_inflight < OUT_W'(MAX_OUTS)) & w_credit;
    assign w_grant  = w_req & imem_gnt;

    assign imem_req  = w_req;
    assign imem_addr = r_req_pc;

    assign w_drop_sum  = r_drop_cnt + DROP_W'(r_inflight);
    assign w_drop_jump = (imem_resp_vld && (w_drop_sum != '0)) ? (w_drop_sum - DROP_W'(1))
                                                               : w_drop_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_req_pc   <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_err_hold <= 1'b0;
        end else if (jump_vld) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop_cnt <= w_drop_jump;
            r_req_pc   <= jump_pc;
            r_resp_pc  <= jump_pc;
            r_err_hold <= 1'b0;
        end else begin
            r_rd_ptr   <= r_rd_ptr + w_pop[PTR_W-1:0];
            r_count    <= r_count - w_pop + CNT_W'(w_push);
            r_inflight <= r_inflight + OUT_W'(w_grant) - OUT_W'(w_push);
            if (w_grant) begin
                r_req_pc <= r_req_pc + XLEN'(4);
            end
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
                r_resp_pc <= r_resp_pc + XLEN'(4);
                if (imem_resp_err) begin
                    r_err_hold <= 1'b1;
                end
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - DROP_W'(1);
            end
        end
    end

    // Storage carries no reset; lanes beyond count are masked on the way out.
    always_ff @(posedge clk) begin
        if (!rst && !jump_vld && w_push) begin
            r_buf_instr[r_wr_ptr] <= imem_resp_instr;
            r_buf_pc[r_wr_ptr]    <= r_resp_pc;
            r_buf_err[r_wr_ptr]   <= imem_resp_err;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FETCH_LEN; gi = gi + 1) begin : g_lane
            logic [PTR_W-1:0] w_slot;
            logic             w_lane_vld;

            assign w_slot     = r_rd_ptr + PTR_W'(gi);
            assign w_lane_vld = ~rst & (CNT_W'(gi) < r_count);

            assign fetch_vld[gi]                 = w_lane_vld;
            assign fetch_instr[gi*XLEN +: XLEN]  = w_lane_vld ? r_buf_instr[w_slot] : '0;
            assign fetch_pc[gi*XLEN +: XLEN]     = w_lane_vld ? r_buf_pc[w_slot]    : '0;
            assign fetch_err[gi]                 = w_lane_vld & r_buf_err[w_slot];
        end
    endgenerate

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a behavioural in-order imem feeds the DUT while a
// scoreboard monitor checks every consumed entry against a queue of expected words.
module tb_fetch_queue;

    localparam int XLEN = 32;
    localparam int FL   = 4;
    localparam int FO   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_req;
    logic [XLEN-1:0]   imem_addr;
    logic              imem_gnt;
    logic              imem_resp_vld;
    logic [XLEN-1:0]   imem_resp_instr;
    logic              imem_resp_err;
    logic              jump_vld;
    logic [XLEN-1:0]   jump_pc;
    logic [FL-1:0]     fetch_vld;
    logic [FL*XLEN-1:0] fetch_instr;
    logic [FL*XLEN-1:0] fetch_pc;
    logic [FL-1:0]     fetch_err;
    logic [FO-1:0]     fetch_offset;

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN(32), .FETCH_LEN(4), .FETCH_OFF(3), .BUF_LEN(8), .MAX_OUTS(2),
        .RESET_PC(32'h0000_0200)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_resp_vld(imem_resp_vld), .imem_resp_instr(imem_resp_instr),
        .imem_resp_err(imem_resp_err),
        .jump_vld(jump_vld), .jump_pc(jump_pc),
        .fetch_vld(fetch_vld), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
        .fetch_err(fetch_err), .fetch_offset(fetch_offset)
    );

    int n_checks   = 0;
    int n_pass     = 0;
    int n_consumed = 0;

    logic [31:0] err_addr  = 32'hFFFF_FFFF;
    logic        resp_hold = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] pend[$];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0] ^ 16'hC0DE, ~pc[15:0]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic expect_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc    = base + 32'(4 * i);
            e.instr = instr_of(e.pc);
            e.err   = (e.pc == err_addr);
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // In-order memory, one cycle from grant to response unless held back.
    initial begin
        logic        g, r, h;
        logic [31:0] a, p;
        imem_resp_vld   = 1'b0;
        imem_resp_instr = '0;
        imem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            g = imem_req && imem_gnt;
            a = imem_addr;
            r = rst;
            h = resp_hold;
            @(posedge clk);
            #1;
            if (r) begin
                pend.delete();
                imem_resp_vld = 1'b0;
            end else begin
                if (g) pend.push_back(a);
                if (!h && pend.size() > 0) begin
                    p = pend.pop_front();
                    imem_resp_vld   = 1'b1;
                    imem_resp_instr = instr_of(p);
                    imem_resp_err   = (p == err_addr);
                end else begin
                    imem_resp_vld = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every lane popped this cycle must match the next expected word.
    initial begin
        int nv, np;
        forever begin
            @(negedge clk);
            if (!rst && !jump_vld) begin
                nv = $countones(fetch_vld);
                np = (int'(fetch_offset) < nv) ? int'(fetch_offset) : nv;
                for (int i = 0; i < np; i++) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL extra_entry: got pc %0h in lane %0d, required none",
                                 fetch_pc[i*XLEN +: XLEN], i);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check($sformatf("pop%0d_err_instr_pc", n_consumed),
                              {63'b0, fetch_err[i], fetch_instr[i*XLEN +: XLEN], fetch_pc[i*XLEN +: XLEN]},
                              {63'b0, e.err, e.instr, e.pc});
                        $display("pop %0d: pc %0h instr %0h err %0b", n_consumed,
                                 fetch_pc[i*XLEN +: XLEN], fetch_instr[i*XLEN +: XLEN], fetch_err[i]);
                        n_consumed++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_seen;
        rst = 1'b1; imem_gnt = 1'b1; jump_vld = 1'b0; jump_pc = '0; fetch_offset = '0;
        cyc();
        @(negedge clk);
        check("rst_req", 128'(imem_req), 128'(0));
        check("rst_vld", 128'(fetch_vld), 128'(0));
        cyc();
        rst = 1'b0;
        expect_seq(32'h200, 40);
        @(negedge clk);
        check("first_req", {95'b0, imem_req, imem_addr}, {95'b0, 1'b1, 32'h200});
        check("first_vld", 128'(fetch_vld), 128'(0));

        // Fill with no pops until credits run out, then drain 4 per cycle.
        repeat (14) cyc();
        imem_gnt = 1'b0; fetch_offset = 3'd4;
        @(negedge clk);
        check("full_req", 128'(imem_req), 128'(0));
        check("full_vld", 128'(fetch_vld), 128'hF);
        check("full_pcs", fetch_pc, {32'h20C, 32'h208, 32'h204, 32'h200});
        cyc();
        @(negedge clk);
        check("drain_lane0", 128'(fetch_pc[31:0]), 128'h210);
        cyc();
        fetch_offset = 3'd0;
        @(negedge clk);
        check("drained_vld", 128'(fetch_vld), 128'(0));

        // Refill, then pop 3, 3 and an over-sized 4 against count=2.
        cyc();
        imem_gnt = 1'b1;
        repeat (14) cyc();
        imem_gnt = 1'b0; fetch_offset = 3'd3;
        @(negedge clk);
        check("refill_pcs", fetch_pc, {32'h22C, 32'h228, 32'h224, 32'h220});
        cyc();
        cyc();
        fetch_offset = 3'd4;
        @(negedge clk);
        check("count2_vld", 128'(fetch_vld), 128'h3);
        check("count2_pcs", fetch_pc, {32'h0, 32'h0, 32'h23C, 32'h238});
        cyc();
        fetch_offset = 3'd0;
        @(negedge clk);
        check("clamp_vld", 128'(fetch_vld), 128'(0));

        // Streaming: 20 grants consumed as they arrive.
        cyc();
        imem_gnt = 1'b1; fetch_offset = 3'd4;
        repeat (20) cyc();
        imem_gnt = 1'b0;
        repeat (4) cyc();
        fetch_offset = 3'd0;
        check("stream_remaining", 128'(exp_q.size()), 128'(4));

        // Four queued, two held in flight, then redirect.
        imem_gnt = 1'b1;
        repeat (4) cyc();
        imem_gnt = 1'b0;
        repeat (3) cyc();
        @(negedge clk);
        check("queued4_pcs", fetch_pc, {32'h29C, 32'h298, 32'h294, 32'h290});
        cyc();
        resp_hold = 1'b1; imem_gnt = 1'b1;
        repeat (2) cyc();
        imem_gnt = 1'b0;
        @(negedge clk);
        check("outs_limit_req", 128'(imem_req), 128'(0));
        cyc();
        jump_vld = 1'b1; jump_pc = 32'h1000; resp_hold = 1'b0;
        check("jump_unconsumed", 128'(exp_q.size()), 128'(4));
        exp_q.delete();
        expect_seq(32'h1000, 1);
        @(negedge clk);
        check("jump_cycle_req", 128'(imem_req), 128'(0));
        cyc();
        jump_vld = 1'b0; imem_gnt = 1'b1;
        @(negedge clk);
        check("post_jump_vld", 128'(fetch_vld), 128'(0));
        check("post_jump_req", {95'b0, imem_req, imem_addr}, {95'b0, 1'b1, 32'h1000});
        cyc();
        imem_gnt = 1'b0;
        repeat (5) cyc();
        fetch_offset = 3'd1;
        @(negedge clk);
        check("jump_target_vld", 128'(fetch_vld), 128'h1);
        check("jump_target_pcs", fetch_pc, {96'h0, 32'h1000});
        cyc();
        fetch_offset = 3'd0;
        check("jump_consumed", 128'(exp_q.size()), 128'(0));

        // Error on the third word holds off requests until a redirect.
        rst = 1'b1; err_addr = 32'h208; imem_gnt = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        expect_seq(32'h200, 4);
        repeat (10) cyc();
        @(negedge clk);
        check("err_vld", 128'(fetch_vld), 128'hF);
        check("err_lanes", 128'(fetch_err), 128'h4);
        req_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (imem_req) req_seen++;
            cyc();
        end
        check("err_hold_req", 128'(req_seen), 128'(0));
        fetch_offset = 3'd4;
        cyc();
        fetch_offset = 3'd0;
        @(negedge clk);
        check("err_popped_vld", {127'b0, imem_req}, 128'(0));
        cyc();
        jump_vld = 1'b1; jump_pc = 32'h3000;
        cyc();
        jump_vld = 1'b0;
        @(negedge clk);
        check("err_resume_req", {95'b0, imem_req, imem_addr}, {95'b0, 1'b1, 32'h3000});
        cyc();
        check("final_remaining", 128'(exp_q.size()), 128'(0));
        check("total_consumed", 128'(n_consumed), 128'(41));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
